// File: rtl/seven_seg_dec_display_if.sv
// ---------------------------------------------------------------------------
// seven_seg_dec_display_if
//   Bundles the host-side and pad-side signals of the decimal seven-segment
//   display driver so that the controller is connected through one port.
//
//   value    : unsigned binary number to display (W_VALUE bits)
//   load     : strobe requesting capture of value
//   dp_mask  : decimal point per digit, bit 0 = units, used live
//   busy     : a binary-to-BCD conversion is in progress
//   overflow : committed value does not fit in N_DIGITS decimal digits
//   abcdefgh : segment drive, bit 7 = a ... bit 1 = g, bit 0 = dp
//   digit    : one-hot digit enable, bit 0 = units
//
//   master : the side that requests conversions and reads the drive lines
//   slave  : the display controller itself
// ---------------------------------------------------------------------------
interface seven_seg_dec_display_if #(
    parameter int W_VALUE  = 16,
    parameter int N_DIGITS = 4
);
    logic [W_VALUE-1:0]  value;
    logic                load;
    logic [N_DIGITS-1:0] dp_mask;
    logic                busy;
    logic                overflow;
    logic [7:0]          abcdefgh;
    logic [N_DIGITS-1:0] digit;

    modport master (
        output value, load, dp_mask,
        input  busy, overflow, abcdefgh, digit
    );

    modport slave (
        input  value, load, dp_mask,
        output busy, overflow, abcdefgh, digit
    );
endinterface

// File: rtl/seven_seg_dec_display.sv
// ---------------------------------------------------------------------------
// seven_seg_dec_display
//   Converts a binary number to decimal with an iterative shift-add-3
//   (double dabble) engine and drives a time-multiplexed seven-segment
//   display with optional leading-zero blanking and an overflow dash.
//
//   clk   : sole clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave modport of seven_seg_dec_display_if
//           (value, load, dp_mask in; busy, overflow, abcdefgh, digit out)
// ---------------------------------------------------------------------------
module seven_seg_dec_display #(
    parameter int W_VALUE        = 16,
    parameter int N_DIGITS       = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter int BLANK_LZ       = 1,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int DIG_ACTIVE_LOW = 0
) (
    input logic                     clk,
    input logic                     rst_n,
    seven_seg_dec_display_if.slave  bus
);

    localparam int BCD_W = 4 * N_DIGITS;
    localparam int CNT_W = $clog2(W_VALUE + 1);
    localparam int RC_W  = $clog2(REFRESH_DIV);
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

    // Smallest value that no longer fits in the available digits.
    localparam logic [63:0] LIMIT = pow10(N_DIGITS);

    function automatic logic is_over(input logic [W_VALUE-1:0] v);
        return (64'(v) >= LIMIT);
    endfunction

    // Every BCD nibble of 5 or more gets 3 added before the next shift.
    function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        r = b;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (b[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = b[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    function automatic logic [7:0] enc8(input logic [3:0] n);
        logic [7:0] e;
        case (n)
            4'd0:    e = 8'hFC;
            4'd1:    e = 8'h60;
            4'd2:    e = 8'hDA;
            4'd3:    e = 8'hF2;
            4'd4:    e = 8'h66;
            4'd5:    e = 8'hB6;
            4'd6:    e = 8'hBE;
            4'd7:    e = 8'hE0;
            4'd8:    e = 8'hFE;
            4'd9:    e = 8'hF6;
            default: e = 8'h00;
        endcase
        return e;
    endfunction

    // Segments a..g (active high) for one digit position; the decimal point
    // is added at the output because it follows dp_mask live.
    function automatic logic [6:0] seg_for(input logic [BCD_W-1:0] d,
                                           input logic             ov,
                                           input logic [IDX_W-1:0] i);
        logic [7:0] e;
        logic       upper_zero;
        int         ii;
        ii = int'(i);
        upper_zero = 1'b1;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (k >= ii && d[4*k +: 4] != 4'd0) begin
                upper_zero = 1'b0;
            end
        end
        e = enc8(d[4*ii +: 4]);
        if (ov) begin
            return 7'b0000001;
        end else if (BLANK_LZ != 0 && ii != 0 && upper_zero) begin
            return 7'b0000000;
        end
        return e[7:1];
    endfunction

    typedef enum logic [1:0] {
        S_IDLE,
        S_PREP,
        S_SHIFT
    } state_t;

    state_t              state;
    logic [W_VALUE-1:0]  bin;
    logic [BCD_W-1:0]    bcd;
    logic [CNT_W-1:0]    cnt;
    logic                ovf_conv;
    logic                pend_valid;
    logic [W_VALUE-1:0]  pend_val;
    logic                busy_r;

    logic [BCD_W-1:0]    disp;
    logic                ovf_disp;
    logic [RC_W-1:0]     rc;
    logic [IDX_W-1:0]    idx;
    logic [6:0]          seg7_r;
    logic [N_DIGITS-1:0] digit_r;

    logic                commit;
    logic [BCD_W-1:0]    bcd_adj;
    logic [BCD_W-1:0]    disp_next;
    logic                ovf_next;
    logic [IDX_W-1:0]    idx_next;
    logic [7:0]          seg_raw;

    assign commit  = (state == S_SHIFT) && (cnt == CNT_W'(W_VALUE));
    assign bcd_adj = add3(bcd);

    // Conversion engine. A capture cycle (PREP) precedes the W_VALUE shifts
    // and the commit happens one edge after the last shift. Any load that
    // arrives while an operation is under way, including on the commit edge,
    // lands in the single pending slot; at commit the pending value is
    // captured directly so busy never drops between back-to-back jobs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            bin        <= '0;
            bcd        <= '0;
            cnt        <= '0;
            ovf_conv   <= 1'b0;
            pend_valid <= 1'b0;
            pend_val   <= '0;
            busy_r     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.load) begin
                        bin      <= bus.value;
                        ovf_conv <= is_over(bus.value);
                        state    <= S_PREP;
                    end
                end
                S_PREP: begin
                    busy_r <= 1'b1;
                    bcd    <= '0;
                    cnt    <= '0;
                    state  <= S_SHIFT;
                    if (bus.load) begin
                        pend_valid <= 1'b1;
                        pend_val   <= bus.value;
                    end
                end
                S_SHIFT: begin
                    if (commit) begin
                        if (bus.load) begin
                            bin        <= bus.value;
                            ovf_conv   <= is_over(bus.value);
                            pend_valid <= 1'b0;
                            state      <= S_PREP;
                        end else if (pend_valid) begin
                            bin        <= pend_val;
                            ovf_conv   <= is_over(pend_val);
                            pend_valid <= 1'b0;
                            state      <= S_PREP;
                        end else begin
                            busy_r <= 1'b0;
                            state  <= S_IDLE;
                        end
                    end else begin
                        bcd <= {bcd_adj[BCD_W-2:0], bin[W_VALUE-1]};
                        bin <= {bin[W_VALUE-2:0], 1'b0};
                        cnt <= cnt + 1'b1;
                        if (bus.load) begin
                            pend_valid <= 1'b1;
                            pend_val   <= bus.value;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Next display contents and scan position, so the registered segment
    // pattern is always built from the same index as the registered enable.
    always_comb begin
        disp_next = disp;
        ovf_next  = ovf_disp;
        idx_next  = idx;
        if (commit) begin
            disp_next = bcd;
            ovf_next  = ovf_conv;
        end
        if (rc == RC_W'(REFRESH_DIV - 1)) begin
            if (idx == IDX_W'(N_DIGITS - 1)) begin
                idx_next = '0;
            end else begin
                idx_next = idx + 1'b1;
            end
        end
    end

    // Display register and scanner. Scanning never pauses for conversions;
    // the old digits remain until the commit edge replaces them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp     <= '0;
            ovf_disp <= 1'b0;
            rc       <= '0;
            idx      <= '0;
            seg7_r   <= 7'b1111110;
            digit_r  <= N_DIGITS'(1);
        end else begin
            disp     <= disp_next;
            ovf_disp <= ovf_next;
            rc       <= (rc == RC_W'(REFRESH_DIV - 1)) ? '0 : rc + 1'b1;
            idx      <= idx_next;
            seg7_r   <= seg_for(disp_next, ovf_next, idx_next);
            digit_r  <= N_DIGITS'(1) << idx_next;
        end
    end

    assign seg_raw      = {seg7_r, bus.dp_mask[idx]};
    assign bus.abcdefgh = (SEG_ACTIVE_LOW != 0) ? ~seg_raw : seg_raw;
    assign bus.digit    = (DIG_ACTIVE_LOW != 0) ? ~digit_r : digit_r;
    assign bus.busy     = busy_r;
    assign bus.overflow = ovf_disp;

endmodule

// File: tb/tb_seven_seg_dec_display.sv
// ---------------------------------------------------------------------------
// tb_seven_seg_dec_display
//   Scoreboard bench for two display controllers: one with the default
//   digit/width/polarity settings and a fast refresh, one with three digits,
//   no blanking and inverted polarities. Load requests feed a behavioural
//   model that schedules commits in decimal arithmetic; a monitor on the
//   falling edge compares busy, overflow, digit and segments every cycle.
// ---------------------------------------------------------------------------
module tb_seven_seg_dec_display;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    seven_seg_dec_display_if #(.W_VALUE(16), .N_DIGITS(4)) busA ();
    seven_seg_dec_display_if #(.W_VALUE(10), .N_DIGITS(3)) busB ();

    seven_seg_dec_display #(
        .W_VALUE(16), .N_DIGITS(4), .REFRESH_DIV(3),
        .BLANK_LZ(1), .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(0)
    ) dutA (
        .clk(clk), .rst_n(rst_n), .bus(busA)
    );

    seven_seg_dec_display #(
        .W_VALUE(10), .N_DIGITS(3), .REFRESH_DIV(4),
        .BLANK_LZ(0), .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(1)
    ) dutB (
        .clk(clk), .rst_n(rst_n), .bus(busB)
    );

    typedef struct {
        int unsigned v;
        bit          ovf;
        int          cyc;
    } commit_t;

    commit_t cqA[$];
    commit_t cqB[$];
    bit      bqA[$];
    bit      bqB[$];

    int vectors = 0;
    int miscompares = 0;
    int edgeNum = 0;

    int wid[2]     = '{16, 10};
    int nd[2]      = '{4, 3};
    int rdv[2]     = '{3, 4};
    bit blank[2]   = '{1'b1, 1'b0};
    bit segLow[2]  = '{1'b1, 1'b0};
    bit digLow[2]  = '{1'b0, 1'b1};

    int          convStart[2];
    int          convCommit[2];
    bit          pendV[2];
    int unsigned pendVal[2];
    int unsigned curVal[2];
    bit          curOvf[2];

    bit          ldA = 1'b0;
    bit          ldB = 1'b0;
    int unsigned valA = 0;
    int unsigned valB = 0;
    bit          randA = 1'b0;
    bit          randB = 1'b0;

    logic [7:0] encTab [0:9] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66,
                                 8'hB6, 8'hBE, 8'hE0, 8'hFE, 8'hF6};

    function automatic int unsigned pow10(int n);
        int unsigned p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    // Decimal view of what a digit position should show (active high).
    function automatic logic [7:0] expSeg(int k, int unsigned v, bit ov, int idx, bit dp);
        logic [7:0] s;
        int unsigned p;
        p = pow10(idx);
        if (ov) s = 8'h02;
        else if (blank[k] && idx > 0 && v < p) s = 8'h00;
        else s = encTab[(v / p) % 10];
        s = s | {7'b0, dp};
        return s;
    endfunction

    task automatic checkOutput(string name, int k, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s dut%0d edge=%0d t=%0t actual=%0h required=%0h",
                     name, k, edgeNum, $time, act, exp);
        end
    endtask

    task automatic pushCommit(int k, int unsigned v, int cyc);
        commit_t c;
        c.v = v;
        c.ovf = (v >= pow10(nd[k]));
        c.cyc = cyc;
        if (k == 0) cqA.push_back(c);
        else cqB.push_back(c);
    endtask

    // Job scheduling: an idle load commits W+2 edges later; loads during a
    // job go to one pending slot (last wins) that starts at the commit edge.
    task automatic modelEdge(int k, bit ld, int unsigned v);
        bit b;
        if (convCommit[k] >= 0 && edgeNum == convCommit[k]) begin
            if (ld) begin
                pendV[k] = 1'b1;
                pendVal[k] = v;
            end
            if (pendV[k]) begin
                convStart[k] = edgeNum - 1;
                convCommit[k] = edgeNum + wid[k] + 2;
                pushCommit(k, pendVal[k], convCommit[k]);
                pendV[k] = 1'b0;
            end
        end else if (convCommit[k] >= 0 && edgeNum < convCommit[k]) begin
            if (ld) begin
                pendV[k] = 1'b1;
                pendVal[k] = v;
            end
        end else if (ld) begin
            convStart[k] = edgeNum;
            convCommit[k] = edgeNum + wid[k] + 2;
            pushCommit(k, v, convCommit[k]);
        end
        b = (edgeNum > convStart[k]) && (edgeNum < convCommit[k]);
        if (k == 0) bqA.push_back(b);
        else bqB.push_back(b);
    endtask

    task automatic modelReset();
        edgeNum = 0;
        cqA.delete();
        cqB.delete();
        bqA.delete();
        bqB.delete();
        for (int k = 0; k < 2; k++) begin
            convStart[k] = -1;
            convCommit[k] = -1;
            pendV[k] = 1'b0;
            pendVal[k] = 0;
            curVal[k] = 0;
            curOvf[k] = 1'b0;
        end
    endtask

    task automatic applyStimulus(int k, int unsigned v);
        if (k == 0) begin
            ldA = 1'b1;
            valA = v;
            busA.load = 1'b1;
            busA.value = 16'(v);
        end else begin
            ldB = 1'b1;
            valB = v;
            busB.load = 1'b1;
            busB.value = 10'(v);
        end
    endtask

    function automatic int unsigned randValA();
        case ($urandom_range(0, 3))
            0: return $urandom_range(0, 9);
            1: return $urandom_range(0, 999);
            2: return $urandom_range(9990, 10010);
            default: return $urandom_range(0, 65535);
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        edgeNum++;
        modelEdge(0, ldA, valA);
        modelEdge(1, ldB, valB);
        #1;
        ldA = 1'b0;
        ldB = 1'b0;
        busA.load = 1'b0;
        busB.load = 1'b0;
        busA.dp_mask = 4'($urandom_range(0, 15));
        busB.dp_mask = 3'($urandom_range(0, 7));
        if (randA && $urandom_range(0, 9) == 0) applyStimulus(0, randValA());
        if (randB && $urandom_range(0, 7) == 0) applyStimulus(1, $urandom_range(0, 1023));
    endtask

    task automatic doReset();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        modelReset();
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: retires scheduled commits and compares all outputs.
    task automatic monitorDut(int k);
        bit          bexp;
        int          idx;
        int          dExp;
        logic [7:0]  sExp;
        logic [31:0] dAct;
        logic [7:0]  sAct;
        logic        busyAct;
        logic        ovfAct;
        logic        dp;
        commit_t     c;
        idx = (edgeNum / rdv[k]) % nd[k];
        if (k == 0) begin
            dAct = 32'(busA.digit);
            sAct = busA.abcdefgh;
            busyAct = busA.busy;
            ovfAct = busA.overflow;
            dp = busA.dp_mask[idx];
        end else begin
            dAct = 32'(busB.digit);
            sAct = busB.abcdefgh;
            busyAct = busB.busy;
            ovfAct = busB.overflow;
            dp = busB.dp_mask[idx];
        end
        if (rst_n) begin
            if ((k == 0 && bqA.size() == 0) || (k == 1 && bqB.size() == 0)) begin
                miscompares++;
                $display("[TB] FAIL busy_queue dut%0d edge=%0d: no expected entry", k, edgeNum);
                bexp = 1'b0;
            end else if (k == 0) begin
                bexp = bqA.pop_front();
            end else begin
                bexp = bqB.pop_front();
            end
            forever begin
                if (k == 0 && cqA.size() > 0 && cqA[0].cyc <= edgeNum) c = cqA.pop_front();
                else if (k == 1 && cqB.size() > 0 && cqB[0].cyc <= edgeNum) c = cqB.pop_front();
                else break;
                if (c.cyc < edgeNum) checkOutput("commit_edge", k, 32'(c.cyc), 32'(edgeNum));
                curVal[k] = c.v;
                curOvf[k] = c.ovf;
            end
        end else begin
            bexp = 1'b0;
        end
        checkOutput("busy", k, 32'(busyAct), 32'(bexp));
        checkOutput("overflow", k, 32'(ovfAct), 32'(curOvf[k]));
        dExp = 1 << idx;
        if (digLow[k]) dExp = (~dExp) & ((1 << nd[k]) - 1);
        checkOutput("digit", k, dAct, 32'(dExp));
        sExp = expSeg(k, curVal[k], curOvf[k], idx, dp);
        if (segLow[k]) sExp = ~sExp;
        checkOutput("segments", k, 32'(sAct), 32'(sExp));
    endtask

    always @(negedge clk) begin
        monitorDut(0);
        monitorDut(1);
    end

    initial begin
        busA.load = 1'b0;
        busA.value = '0;
        busA.dp_mask = 4'b0101;
        busB.load = 1'b0;
        busB.value = '0;
        busB.dp_mask = 3'b010;
        modelReset();
        doReset();
        randB = 1'b1;
        repeat (5) tick();

        applyStimulus(0, 1234);
        repeat (35) tick();
        applyStimulus(0, 7);
        repeat (35) tick();
        applyStimulus(0, 0);
        repeat (35) tick();
        applyStimulus(0, 10000);
        repeat (35) tick();
        applyStimulus(0, 9999);
        repeat (35) tick();

        applyStimulus(0, 'h42);
        repeat (6) tick();
        applyStimulus(0, 'h100);
        tick();
        applyStimulus(0, 'h200);
        repeat (60) tick();

        applyStimulus(0, 12);
        repeat (35) tick();
        applyStimulus(0, 999);
        repeat (8) tick();
        doReset();
        repeat (40) tick();

        randB = 1'b0;
        repeat (30) tick();
        applyStimulus(1, 1000);
        repeat (35) tick();
        applyStimulus(1, 999);
        repeat (35) tick();
        applyStimulus(1, 0);
        repeat (30) tick();

        randA = 1'b1;
        randB = 1'b1;
        repeat (400) tick();
        randA = 1'b0;
        randB = 1'b0;
        repeat (60) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seven_seg_dec_display.md
SEVEN_SEG_DEC_DISPLAY -- requirements
Module: seven_seg_dec_display

Interface
REQ-001 SHALL have parameter W_VALUE, default 16: binary input width, 4..32.
REQ-002 SHALL have parameter N_DIGITS, default 4: number of decimal digits driven, 1..8.
REQ-003 SHALL have parameter REFRESH_DIV, default 50000: clock cycles each digit stays active, >=2.
REQ-004 SHALL have parameter BLANK_LZ, default 1: 1 blanks leading zeros.
REQ-005 SHALL have parameter SEG_ACTIVE_LOW, default 1: 1 inverts abcdefgh at the output.
REQ-006 SHALL have parameter DIG_ACTIVE_LOW, default 0: 1 inverts digit at the output.
REQ-007 SHALL have port clk, input, 1: sole clock; all state changes on its rising edge.
REQ-008 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-009 SHALL have port value, input, W_VALUE: unsigned binary number to display.
REQ-010 SHALL have port load, input, 1: strobe requesting capture of value.
REQ-011 SHALL have port dp_mask, input, N_DIGITS: decimal point per digit (bit 0 = units), sampled live.
REQ-012 SHALL have port busy, output, 1: high while a conversion is in progress.
REQ-013 SHALL have port overflow, output, 1: high while the committed value exceeds the display range.
REQ-014 SHALL have port abcdefgh, output, 8: segments; bit 7 = a ... bit 1 = g, bit 0 = h (decimal point).
REQ-015 SHALL have port digit, output, N_DIGITS: one-hot digit enable; bit 0 = units.

Function
REQ-016 SHALL accept load when busy=0: capture value, set busy on the next edge, and run an iterative shift-add-3 (double dabble) conversion of exactly W_VALUE shift cycles.
REQ-017 SHALL commit the converted digits to the display register on the edge after the last shift, clearing busy on that same edge; load accepted at edge T -> busy high T+1..T+W_VALUE+1, new digits displayed from edge T+W_VALUE+2.
REQ-018 SHALL, on load while busy=1, store value in a single pending register (last request wins) and start its conversion on the cycle after the current commit; busy stays high without a low gap.
REQ-019 SHALL, on load coinciding with the commit cycle, treat it as pending per REQ-018.
REQ-020 SHALL compute overflow at capture as value >= 10**N_DIGITS (constant compare; never true when 2**W_VALUE <= 10**N_DIGITS) and apply it at commit.
REQ-021 SHALL, while overflow=1, show segment g only (dash, 8'b0000_0010 before polarity) on every digit, dp still from dp_mask; leading-zero blanking does not apply.
REQ-022 SHALL use the active-high encoding 0=FC,1=60,2=DA,3=F2,4=66,5=B6,6=BE,7=E0,8=FE,9=F6 (hex, bit 7 = a), then OR in dp_mask bit as bit 0.
REQ-023 SHALL, when BLANK_LZ=1, blank (all segments off except dp) every digit above the most significant nonzero digit; the units digit is never blanked (value 0 shows "0").
REQ-024 SHALL scan digits with a refresh counter counting 0..REFRESH_DIV-1; on wrap the digit index increments, wrapping from N_DIGITS-1 to 0.
REQ-025 SHALL keep digit exactly one-hot (before polarity) at all times, matching the index whose segments are on abcdefgh in the same cycle (registered outputs, no glitch between digit and segments).
REQ-026 SHALL not interrupt scanning during conversion; the previously committed digits stay displayed until commit.

Reset
REQ-027 SHALL, while rst_n=0, asynchronously clear: busy=0, overflow=0, pending flag=0, display register all zero, refresh counter=0, digit index=0.
REQ-028 SHALL, after reset, drive digit = units enable and abcdefgh = encoding of "0" (polarity applied), dp from dp_mask; other digits blank if BLANK_LZ=1.
REQ-029 SHALL, on reset mid-conversion, discard the conversion and pending value; no commit occurs after release.

Verification
REQ-030 Defaults, load value=1234 at edge T -> busy high for 17 cycles, digits 4,3,2,1 (units..thousands) from T+18, overflow=0.
REQ-031 Defaults, value=7 -> units shows 7 (hex E0 before inversion), tens..thousands blanked; value=0 -> units "0" only.
REQ-032 Defaults, value=10000 -> overflow=1, all four digits show dash; then value=9999 -> overflow=0, "9999".
REQ-033 load 0x0042 then at busy 5 cycles later load 0x0100 then 0x0200 -> first commit shows 66, then busy continuous, final display 512.
REQ-034 REFRESH_DIV=4, N_DIGITS=3 -> digit sequence 001,010,100,001 each held 4 cycles; digit/segment pairing checked every cycle.
REQ-035 Assert rst_n=0 mid-conversion of 999 after prior commit of 12 -> immediate busy=0, display "0"; no later commit of 999.
